// File: rtl/axis_trans_pkg.sv
// Shared function codes and the WIDTH+1 -> WIDTH reduction used by axis_trans.
// Macro AXIS_TRANS_SAT_EN selects saturation; when it is undefined, results wrap.
package axis_trans_pkg;

  localparam int FN_SUB    = 0;
  localparam int FN_ADD    = 1;
  localparam int FN_RSUB   = 2;
  localparam int FN_NEG    = 3;
  localparam int FN_NADD   = 4;
  localparam int FN_PASS_S = 5;

  // Widest result the reduction handles. Callers sign-extend into this container.
  localparam int         SAT_MAX_W = 64;
  localparam logic [6:0] SAT_SPAN  = 7'(SAT_MAX_W + 1);

  // Reduce a sign-extended wide value to 'width' bits.
  // The returned value is sign-extended from bit width-1.
  function automatic logic [SAT_MAX_W:0] sat_reduce(input logic [SAT_MAX_W:0] wide,
                                                    input logic [6:0]         width);
    logic [SAT_MAX_W:0] keep_mask;
    logic [SAT_MAX_W:0] mag_mask;
    logic [SAT_MAX_W:0] res;
    logic               wrap_sign;
`ifdef AXIS_TRANS_SAT_EN
    logic               top;
`endif
    keep_mask = {(SAT_MAX_W + 1){1'b1}} >> (SAT_SPAN - width);
    mag_mask  = keep_mask >> 1;
    wrap_sign = wide[width - 7'd1];
    res       = (wide & keep_mask) | ({(SAT_MAX_W + 1){wrap_sign}} & ~keep_mask);
`ifdef AXIS_TRANS_SAT_EN
    // The value is in range only if every bit from width-1 upward matches the true sign.
    top = wide[SAT_MAX_W];
    if (((wide ^ {(SAT_MAX_W + 1){top}}) & ~mag_mask) != '0) begin
      res = top ? ~mag_mask : mag_mask;
    end
`endif
    return res;
  endfunction

endpackage

// File: rtl/axis_trans_addsub.sv
// Combinational signed add/sub at WIDTH+1 bits with operand inversion and reduction.
// Reduction follows AXIS_TRANS_SAT_EN through axis_trans_pkg::sat_reduce.
module axis_addsub
  import axis_trans_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inv_a,
  input  logic             inv_b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     b_ext;
  logic [WIDTH:0]     op_a;
  logic [WIDTH:0]     op_b;
  logic [WIDTH:0]     sum;
  logic [SAT_MAX_W:0] wide;

  // Negation is expressed as ~x + 1, so each inversion contributes a carry-in of one.
  always_comb begin
    a_ext = {a[WIDTH-1], a};
    b_ext = {b[WIDTH-1], b};
    op_a  = inv_a ? ~a_ext : a_ext;
    op_b  = inv_b ? ~b_ext : b_ext;
    sum   = op_a + op_b + (WIDTH + 1)'(inv_a) + (WIDTH + 1)'(inv_b);
    wide  = (SAT_MAX_W + 1)'($signed(sum));
    y     = WIDTH'(sat_reduce(wide, 7'(WIDTH)));
  end

endmodule

// File: rtl/axis_trans.sv
// Registered fixed-point axis transform: f_out = op(f_in, s_in), with one cycle of latency.
// The operation is chosen by FUNC. Macro AXIS_TRANS_SAT_EN selects saturation instead of wrap.
module axis_trans
  import axis_trans_pkg::*;
#(
  parameter int M    = 4,
  parameter int N    = 8,
  parameter int FUNC = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [M+N-1:0]       f_in,
  input  logic [M+N-1:0]       s_in,
  output logic [M+N-1:0]       f_out
);

  localparam int WIDTH = M + N;

  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] f_out_d;
  logic [WIDTH-1:0] f_out_q;

  generate
    if (FUNC == FN_SUB || FUNC == FN_ADD || FUNC == FN_RSUB ||
        FUNC == FN_NEG || FUNC == FN_NADD) begin : g_arith
      localparam bit INV_A = (FUNC == FN_RSUB) || (FUNC == FN_NEG) || (FUNC == FN_NADD);
      localparam bit INV_B = (FUNC == FN_SUB) || (FUNC == FN_NADD);
      localparam bit USE_B = (FUNC != FN_NEG);

      // With USE_B clear, the second operand is forced to zero so that an X on s_in cannot propagate.
      logic [WIDTH-1:0] b_sel;
      assign b_sel = USE_B ? s_in : '0;

      axis_addsub #(
        .WIDTH (WIDTH)
      ) u_addsub (
        .a     (f_in),
        .b     (b_sel),
        .inv_a (INV_A),
        .inv_b (INV_B),
        .y     (result)
      );
    end else if (FUNC == FN_PASS_S) begin : g_pass_s
      assign result = s_in;
    end else begin : g_pass_f
      assign result = f_in;
    end
  endgenerate

  always_comb begin
    f_out_d = result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_out_q <= '0;
    end else begin
      f_out_q <= f_out_d;
    end
  end

  assign f_out = f_out_q;

endmodule

// File: tb/tb_axis_trans.sv
// Directed and random-pair bench for axis_trans with M=4 and N=8, for FUNC codes 0 through 6.
// Expected values depend on AXIS_TRANS_SAT_EN.
module tb_axis_trans;

  localparam int M    = 4;
  localparam int N    = 8;
  localparam int W    = M + N;
  localparam int NFN  = 7;
  localparam int HI_LIM = 2047;
  localparam int LO_LIM = -2048;

`ifdef AXIS_TRANS_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] f_in;
  logic [W-1:0] s_in;
  logic [W-1:0] f_out [NFN];

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NFN; g++) begin : g_dut
      axis_trans #(
        .M    (M),
        .N    (N),
        .FUNC (g)
      ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .f_in  (f_in),
        .s_in  (s_in),
        .f_out (f_out[g])
      );
    end
  endgenerate

  typedef struct {
    int f;
    int s;
    int fn;
    int exp;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Operands are driven on the falling edge and captured by the next rising edge.
  // The result is sampled 1 time unit after that rising edge.
  task automatic applyStimulus(input int f, input int s);
    @(negedge clk);
    f_in = W'(f);
    s_in = W'(s);
    @(posedge clk);
    #1;
  endtask

  // Golden model: compute the exact result, wrap it to W+1 bits, then saturate or wrap it to W bits.
  function automatic logic [W-1:0] model(input int fn, input int f, input int s);
    int r;
    logic [W:0] t;
    case (fn)
      0: r = f - s;
      1: r = f + s;
      2: r = s - f;
      3: r = -f;
      4: r = -(f + s);
      5: return W'(s);
      default: return W'(f);
    endcase
    t = (W + 1)'(r);
    r = int'($signed(t));
    if (SAT) begin
      if (r > HI_LIM) r = HI_LIM;
      if (r < LO_LIM) r = LO_LIM;
    end
    return W'(r);
  endfunction

  initial begin
    logic [W-1:0] exp_q [NFN];
    bit           prev_rst;

    vecs.push_back('{-30,   80,    0, -110});
    vecs.push_back('{-30,   80,    1,   50});
    vecs.push_back('{-30,   80,    2,  110});
    vecs.push_back('{-30,   80,    5,   80});
    vecs.push_back('{-30,   80,    6,  -30});
    vecs.push_back('{-45,  -20,    0,  -25});
    vecs.push_back('{-45,  -20,    1,  -65});
    vecs.push_back('{-45,  -20,    4,   65});
    vecs.push_back('{  0, -100,    0,  100});
    vecs.push_back('{  0, -100,    1, -100});
    vecs.push_back('{2047, -2047,  1,    0});
    vecs.push_back('{2047, -2047,  0, SAT ?  2047 :    -2});
    vecs.push_back('{-2048,    0,  3, SAT ?  2047 : -2048});
    vecs.push_back('{-2048,   -1,  1, SAT ? -2048 :  2047});
    vecs.push_back('{  77,    0,   3,  -77});

    rst  = 1'b1;
    f_in = W'(50);
    s_in = W'(100);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NFN; g++) checkOutput($sformatf("reset_fn%0d", g), f_out[g], '0);
    end

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("release_fn0", f_out[0], W'(-50));
    checkOutput("release_fn1", f_out[1], W'(150));
    checkOutput("release_fn6", f_out[6], W'(50));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].f, vecs[i].s);
      checkOutput($sformatf("vec%0d_fn%0d", i, vecs[i].fn), f_out[vecs[i].fn], W'(vecs[i].exp));
    end

    // Back-to-back random pairs, with a one-cycle reset pulse in the middle of the stream.
    prev_rst = 1'b0;
    for (int cyc = 0; cyc <= 1000; cyc++) begin
      int f;
      int s;
      @(negedge clk);
      if (cyc > 0) begin
        for (int g = 0; g < NFN; g++)
          checkOutput($sformatf("rand%0d_fn%0d", cyc, g), f_out[g], prev_rst ? '0 : exp_q[g]);
      end
      f = int'($urandom_range(0, 4095)) - 2048;
      s = int'($urandom_range(0, 4095)) - 2048;
      rst  = (cyc == 500);
      f_in = W'(f);
      s_in = W'(s);
      prev_rst = rst;
      for (int g = 0; g < NFN; g++) exp_q[g] = model(g, f, s);
    end

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
